// File: rtl/encrypt_pipe_rotate.sv
// Rotation stage of the encrypt/decrypt pipeline.
// Applies a three-rotor, odometer-stepped Caesar shift to alphabetic characters.
// Case is preserved. All other bytes pass through unchanged.
// Timing: input accepted at edge N -> stage-1 bank at N, stage-2 bank at N+1, dout/en_out at N+2.
module encrypt_pipe_rotate (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [7:0]  k1,
    input  logic [7:0]  k2,
    input  logic [7:0]  k3,
    input  logic [2:0]  rot_freq,
    input  logic        shift_en,
    input  logic        shift_amt,
    input  logic        mode,
    input  logic        is_alpha_upper_case,
    input  logic        is_alpha_low_case,
    input  logic [31:0] extended_shift_data,
    output logic [7:0]  dout,
    output logic        en_out
);

    // Reduce an 8-bit value mod 26 by repeated compare/subtract (at most 9 steps for 255).
    function automatic logic [4:0] mod26(input logic [7:0] v);
        logic [7:0] t;
        t = v;
        for (int i = 0; i < 9; i++) begin
            if (t >= 8'd26) t = t - 8'd26;
        end
        return t[4:0];
    endfunction

    logic [4:0] r1, r2, r3;
    logic [2:0] cnt;

    logic [4:0] s1_idx;
    logic       s1_upper;
    logic [7:0] s1_byte;
    logic       s1_mode;
    logic [4:0] s1_shift;
    logic       s1_rot;
    logic       s1_valid;

    logic [7:0] s2_byte;
    logic       s2_valid;

    logic       alpha;
    logic       do_step;
    logic [7:0] shift_sum;
    logic [4:0] shift_now;

    logic [4:0] r1_d, r2_d, r3_d;
    logic [2:0] cnt_d;
    logic [5:0] r1_inc;

    logic [5:0] add_v, sub_v;
    logic [4:0] new_idx;
    logic [7:0] rot_byte;

    logic       unused_bits;
    assign unused_bits = ^extended_shift_data[31:13];

    assign alpha   = en & (is_alpha_upper_case | is_alpha_low_case);
    assign do_step = alpha & shift_en;

    // Shift for the current character, from the rotor values held before its own step.
    always_comb begin
        shift_sum = {3'b000, mod26(k1)} + {3'b000, mod26(k2)} + {3'b000, mod26(k3)}
                  + {3'b000, r1} + {3'b000, r2} + {3'b000, r3};
        shift_now = mod26(shift_sum);
    end

    // Odometer next-state: cnt gates r1 steps; r1 carries into r2, r2 into r3.
    always_comb begin
        r1_d   = r1;
        r2_d   = r2;
        r3_d   = r3;
        cnt_d  = cnt;
        r1_inc = {1'b0, r1} + (shift_amt ? 6'd2 : 6'd1);
        if (do_step) begin
            if (cnt >= rot_freq) begin
                cnt_d = 3'd0;
                if (r1_inc >= 6'd26) begin
                    r1_d = 5'(r1_inc - 6'd26);
                    if (r2 == 5'd25) begin
                        r2_d = 5'd0;
                        r3_d = (r3 == 5'd25) ? 5'd0 : r3 + 5'd1;
                    end else begin
                        r2_d = r2 + 5'd1;
                    end
                end else begin
                    r1_d = r1_inc[4:0];
                end
            end else begin
                cnt_d = cnt + 3'd1;
            end
        end
    end

    // Rotor and step-counter state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r1  <= 5'd0;
            r2  <= 5'd0;
            r3  <= 5'd0;
            cnt <= 3'd0;
        end else begin
            r1  <= r1_d;
            r2  <= r2_d;
            r3  <= r3_d;
            cnt <= cnt_d;
        end
    end

    // Stage-1 bank: capture the character, its case, direction and shift.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_idx   <= 5'd0;
            s1_upper <= 1'b0;
            s1_byte  <= 8'h00;
            s1_mode  <= 1'b0;
            s1_shift <= 5'd0;
            s1_rot   <= 1'b0;
            s1_valid <= 1'b0;
        end else begin
            s1_idx   <= extended_shift_data[12:8];
            s1_upper <= is_alpha_upper_case;
            s1_byte  <= extended_shift_data[7:0];
            s1_mode  <= mode;
            s1_shift <= shift_now;
            s1_rot   <= do_step;
            s1_valid <= en;
        end
    end

    // Modular add/subtract with a single +/-26 correction, then re-encode as ASCII.
    always_comb begin
        add_v = {1'b0, s1_idx} + {1'b0, s1_shift};
        if (add_v >= 6'd26) add_v = add_v - 6'd26;
        sub_v = {1'b0, s1_idx} - {1'b0, s1_shift};
        if (s1_idx < s1_shift) sub_v = sub_v + 6'd26;
        new_idx  = s1_mode ? add_v[4:0] : sub_v[4:0];
        rot_byte = s1_rot ? ({3'b000, new_idx} + (s1_upper ? 8'h41 : 8'h61)) : s1_byte;
    end

    // Stage-2 bank: hold the processed byte and its valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_byte  <= 8'h00;
            s2_valid <= 1'b0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) s2_byte <= rot_byte;
        end
    end

    // Output register; dout holds its last value across bubbles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout   <= 8'h00;
            en_out <= 1'b0;
        end else begin
            en_out <= s2_valid;
            if (s2_valid) dout <= s2_byte;
        end
    end

endmodule

// File: tb/tb_encrypt_pipe_rotate.sv
// Self-checking bench for encrypt_pipe_rotate: directed steps, expected bytes queued at drive time.
module tb_encrypt_pipe_rotate;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic [7:0]  k1 = 8'd0, k2 = 8'd0, k3 = 8'd0;
    logic [2:0]  rot_freq = 3'd0;
    logic        shift_en = 1'b1;
    logic        shift_amt = 1'b0;
    logic        mode = 1'b1;
    logic        is_alpha_upper_case = 1'b0;
    logic        is_alpha_low_case = 1'b0;
    logic [31:0] extended_shift_data = 32'd0;
    logic [7:0]  dout;
    logic        en_out;

    int n_cmp = 0;
    int n_fail = 0;

    // Reference model state.
    int m_r1 = 0, m_r2 = 0, m_r3 = 0, m_cnt = 0;
    logic [7:0] last_d = 8'h00;
    logic [8:0] exp_q[$];

    encrypt_pipe_rotate dut (
        .clk                 (clk),
        .rst                 (rst),
        .en                  (en),
        .k1                  (k1),
        .k2                  (k2),
        .k3                  (k3),
        .rot_freq            (rot_freq),
        .shift_en            (shift_en),
        .shift_amt           (shift_amt),
        .mode                (mode),
        .is_alpha_upper_case (is_alpha_upper_case),
        .is_alpha_low_case   (is_alpha_low_case),
        .extended_shift_data (extended_shift_data),
        .dout                (dout),
        .en_out              (en_out)
    );

    always #5 clk = ~clk;

    task automatic check_out(input string tag, input logic ev, input logic [7:0] ed);
        n_cmp++;
        assert (en_out === ev) else begin
            n_fail++;
            $error("FAIL %s en_out: observed %b expected %b", tag, en_out, ev);
        end
        n_cmp++;
        assert (dout === ed) else begin
            n_fail++;
            $error("FAIL %s dout: observed %h expected %h", tag, dout, ed);
        end
    endtask

    // Drive one cycle (valid v, byte c), model it, clock, then check the entry from two edges ago.
    task automatic send(input logic v, input logic [7:0] c);
        logic up, lo, al;
        int idx, s, ni;
        logic [7:0] e;
        up  = (c >= 8'h41 && c <= 8'h5a);
        lo  = (c >= 8'h61 && c <= 8'h7a);
        al  = up | lo;
        idx = up ? int'(c) - 65 : (lo ? int'(c) - 97 : 0);
        en                  = v;
        is_alpha_upper_case = up;
        is_alpha_low_case   = lo;
        extended_shift_data = {19'd0, 5'(idx), c};
        e = c;
        if (v && al && shift_en) begin
            s  = (int'(k1) % 26 + int'(k2) % 26 + int'(k3) % 26 + m_r1 + m_r2 + m_r3) % 26;
            ni = mode ? (idx + s) % 26 : (idx - s + 26) % 26;
            e  = 8'((up ? 65 : 97) + ni);
            if (m_cnt >= int'(rot_freq)) begin
                m_cnt = 0;
                m_r1  = m_r1 + (shift_amt ? 2 : 1);
                if (m_r1 >= 26) begin
                    m_r1 = m_r1 - 26;
                    m_r2 = m_r2 + 1;
                    if (m_r2 == 26) begin
                        m_r2 = 0;
                        m_r3 = (m_r3 + 1) % 26;
                    end
                end
            end else begin
                m_cnt = m_cnt + 1;
            end
        end
        exp_q.push_back({v, e});
        @(posedge clk);
        #1;
        if (exp_q.size() > 2) begin
            logic [8:0] ent;
            ent = exp_q.pop_front();
            if (ent[8]) last_d = ent[7:0];
            check_out("pipe", ent[8], last_d);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send(1'b0, 8'h00);
    endtask

    // Asynchronous reset pulse: outputs must clear before any clock edge.
    task automatic do_reset();
        en = 1'b0;
        rst = 1'b0;
        #1;
        check_out("async_rst", 1'b0, 8'h00);
        exp_q.delete();
        m_r1 = 0; m_r2 = 0; m_r3 = 0; m_cnt = 0;
        last_d = 8'h00;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check_out("reset", 1'b0, 8'h00);
        rst = 1'b1;

        // Basic stepping: A,A,A -> A,B,C.
        send(1, "A"); send(1, "A"); send(1, "A");
        idle(3);

        // Wrap with case preserved, encrypt then decrypt.
        do_reset();
        k1 = 8'd3; rot_freq = 3'd7;
        send(1, "Y"); send(1, "x");
        idle(3);
        do_reset();
        mode = 1'b0;
        send(1, "B"); send(1, "a");
        idle(3);

        // rot_freq=2 with non-alpha bytes mixed in.
        do_reset();
        k1 = 8'd0; mode = 1'b1; rot_freq = 3'd2;
        send(1, "a"); send(1, "a"); send(1, "a"); send(1, "5");
        send(1, "a"); send(1, 8'h20); send(1, "b"); send(1, "a");
        idle(3);

        // Odometer carry into r2, then shift_amt=1.
        do_reset();
        rot_freq = 3'd0;
        for (int i = 0; i < 28; i++) send(1, "A");
        shift_amt = 1'b1;
        send(1, "A"); send(1, "A");
        shift_amt = 1'b0;
        idle(3);

        // shift_en=0 passes through and freezes the rotors.
        shift_en = 1'b0;
        send(1, "M");
        shift_en = 1'b1;
        send(1, "A");
        idle(3);

        // Large keys with bubbles, both directions.
        do_reset();
        k1 = 8'd200; k2 = 8'd255; k3 = 8'd77; rot_freq = 3'd1;
        send(1, "H"); send(0, 8'h00); send(1, "e"); send(1, "z");
        mode = 1'b0;
        send(1, "Q"); send(1, "c");
        mode = 1'b1;
        idle(3);

        // Mid-stream reset with characters in flight.
        do_reset();
        k1 = 8'd0; k2 = 8'd0; k3 = 8'd0; rot_freq = 3'd0;
        send(1, "A"); send(1, "B"); send(1, "C");
        do_reset();
        send(1, "A");
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
